// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master sequencer in front of a single-port sync RAM on a tri-state data bus.
// Ties go to m0 by default; define RAM_ARB_RR_EN for round-robin tie-breaking.
module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_oe,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_id;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;

  logic                w_any_req;
  logic                w_accept;
  logic                w_grant;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  assign w_any_req = m0_req | m1_req;
  assign w_accept  = (r_state == ST_IDLE) && w_any_req;

`ifdef RAM_ARB_RR_EN
  // r_rr_ptr names the master that wins the next tie; it flips to the loser on every accept.
  logic r_rr_ptr;

  assign w_grant = (m0_req && m1_req) ? r_rr_ptr : m1_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= 1'b0;
    end else if (w_accept) begin
      r_rr_ptr <= ~w_grant;
    end
  end
`else
  assign w_grant = m1_req & ~m0_req;
`endif

  assign w_sel_we    = w_grant ? m1_we    : m0_we;
  assign w_sel_addr  = w_grant ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_grant ? m1_wdata : m0_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Command is captured once at accept; later changes on the master's fields are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_id    <= w_grant;
      r_we    <= w_sel_we;
      r_addr  <= w_sel_addr;
      r_wdata <= w_sel_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (r_state == ST_RD_DATA) begin
      if (r_id) begin
        r_rdata1 <= ram_data;
      end else begin
        r_rdata0 <= ram_data;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    ram_we       = 1'b0;
    ram_oe       = 1'b0;
    m0_ack       = 1'b0;
    m1_ack       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_next_state = w_sel_we ? ST_WR : ST_RD_ADDR;
        end
      end
      ST_WR: begin
        ram_we       = 1'b1;
        w_next_state = ST_DONE;
      end
      ST_RD_ADDR: begin
        w_next_state = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        ram_oe       = 1'b1;
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
        m0_ack       = ~r_id;
        m1_ack       = r_id;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign ram_addr = r_addr;
  assign ram_data = (r_state == ST_WR) ? r_wdata : {DATA_W{1'bz}};
  assign busy     = (r_state != ST_IDLE);
  assign m0_rdata = r_rdata0;
  assign m1_rdata = r_rdata1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vector table, hand-built corner sequences, random traffic vs a
// transaction-level model of arbitration, latency and RAM contents.
`timescale 1ns/1ps
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m0_req, m0_we, m1_req, m1_we;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic       m0_ack, m1_ack;
  logic [7:0] m0_rdata, m1_rdata;
  logic [7:0] ram_addr;
  logic       ram_we, ram_oe, busy;
  tri1  [7:0] ram_data;

  bit   [7:0] ram_mem     [256];
  bit         ram_written [256];
  logic [7:0] ram_rd_buf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_oe(ram_oe), .ram_data(ram_data),
    .busy(busy)
  );

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  // RAM model: sync write, read buffer loaded on every non-write edge, drives bus while oe.
  always @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_addr]     <= ram_data;
      ram_written[ram_addr] <= 1'b1;
    end else begin
      ram_rd_buf <= ram_written[ram_addr] ? ram_mem[ram_addr] : init_val(ram_addr);
    end
  end
  assign ram_data = ram_oe ? ram_rd_buf : 8'hzz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int m, input logic r, input logic we, input logic [7:0] a,
                       input logic [7:0] d);
    if (m == 0) begin
      m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d;
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One isolated transfer; reports what was seen on every cycle until the ack.
  task automatic do_txn(input int m, input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                        output int lat, output int busy_n, output int we_n, output int oe_n,
                        output logic [7:0] rdata, output logic [7:0] wr_addr,
                        output logic [7:0] wr_data, output int stray, output logic busy_after,
                        output logic [7:0] addr_after);
    lat = 99; busy_n = 0; we_n = 0; oe_n = 0; stray = 0;
    rdata = 8'h00; wr_addr = 8'h00; wr_data = 8'h00;
    drive(m, 1'b1, we, addr, wdata);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (ram_we) begin
        we_n++;
        wr_addr = ram_addr;
        wr_data = ram_data;
      end
      if (ram_oe) oe_n++;
      if ((m == 0 && m1_ack) || (m == 1 && m0_ack)) stray++;
      if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) begin
        lat   = c;
        rdata = (m == 0) ? m0_rdata : m1_rdata;
        break;
      end
    end
    drive(m, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    busy_after = busy;
    addr_after = ram_addr;
  endtask

  typedef struct {
    int         m;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    int         exp_lat;
  } vec_t;

  vec_t vecs [9];

  // Random-phase model state.
  bit   [7:0] mm [256];
  int         k, next_acc, cur_e, cur_ack, cur_w, pref, w;
  bit         cur_v, cur_we, in_t, e_we, e_oe, e_ack0, e_ack1;
  logic [7:0] cur_a, cur_d, cur_rd, exp_addr, e_dat;
  logic [7:0] exp_rd [2];
  bit         pend   [2];
  logic       pwe    [2];
  logic [7:0] pa     [2];
  logic [7:0] pd     [2];

  initial begin
    int         lat, busy_n, we_n, oe_n, stray, n_ack, last_c, winner;
    logic [7:0] rdata, wr_addr, wr_data, addr_after;
    logic       busy_after;

    vecs[0] = '{0, 1'b1, 8'h05, 8'hA5, 8'h00, 2};
    vecs[1] = '{1, 1'b0, 8'h05, 8'h00, 8'hA5, 3};
    vecs[2] = '{1, 1'b1, 8'h20, 8'h22, 8'h00, 2};
    vecs[3] = '{0, 1'b0, 8'h20, 8'h00, 8'h22, 3};
    vecs[4] = '{0, 1'b1, 8'hFF, 8'h00, 8'h00, 2};
    vecs[5] = '{1, 1'b0, 8'hFF, 8'h00, 8'h00, 3};
    vecs[6] = '{1, 1'b1, 8'h00, 8'hFF, 8'h00, 2};
    vecs[7] = '{0, 1'b0, 8'h00, 8'h00, 8'hFF, 3};
    vecs[8] = '{0, 1'b0, 8'h7F, 8'h00, 8'h25, 3};

    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_we", ram_we, 1'b0);
    chk("rst_oe", ram_oe, 1'b0);
    chk("rst_acks", {m0_ack, m1_ack}, 2'b00);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 16'h0000);
    chk("rst_addr", ram_addr, 8'h00);
    chk("rst_bus_z", ram_data, 8'hFF);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, busy_n, we_n, oe_n,
             rdata, wr_addr, wr_data, stray, busy_after, addr_after);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_busy_cycles", i), busy_n, vecs[i].exp_lat);
      chk($sformatf("v%0d_we_cycles", i), we_n, vecs[i].we ? 1 : 0);
      chk($sformatf("v%0d_oe_cycles", i), oe_n, vecs[i].we ? 0 : 1);
      chk($sformatf("v%0d_stray_ack", i), stray, 0);
      chk($sformatf("v%0d_idle_after", i), busy_after, 1'b0);
      chk($sformatf("v%0d_addr_hold", i), addr_after, vecs[i].addr);
      if (vecs[i].we) begin
        chk($sformatf("v%0d_wr_bus", i), {wr_addr, wr_data}, {vecs[i].addr, vecs[i].wdata});
      end else begin
        chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      end
    end

    // Reset in the middle of a write: strobe and bus drop at once, no ack, memory untouched.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 8'h30, 8'h33);
    @(posedge clk);
    #1;
    chk("t4_wr_active", ram_we, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t4_we_drop", ram_we, 1'b0);
    chk("t4_bus_z", ram_data, 8'hFF);
    chk("t4_busy", busy, 1'b0);
    chk("t4_rdata_clr", {m0_rdata, m1_rdata}, 16'h0000);
    chk("t4_addr_clr", ram_addr, 8'h00);
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    n_ack = 0;
    repeat (3) begin
      @(negedge clk);
      if (m0_ack || m1_ack) n_ack++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (m0_ack || m1_ack) n_ack++;
    end
    chk("t4_no_ack", n_ack, 0);
    do_txn(1, 1'b0, 8'h30, 8'h00, lat, busy_n, we_n, oe_n, rdata, wr_addr, wr_data, stray,
           busy_after, addr_after);
    chk("t4_readback", rdata, init_val(8'h30));
    chk("t4_readback_lat", lat, 3);

    // Both masters hold write requests continuously.
    reset_pulse();
    drive(0, 1'b1, 1'b1, 8'h10, 8'h11);
    drive(1, 1'b1, 1'b1, 8'h20, 8'h22);
    n_ack = 0;
    last_c = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (m0_ack && m1_ack) chk("t3_double_ack", 1, 0);
      if (m0_ack || m1_ack) begin
        winner = m1_ack ? 1 : 0;
`ifdef RAM_ARB_RR_EN
        chk($sformatf("t3_grant%0d", n_ack), winner, n_ack % 2);
`else
        chk($sformatf("t3_grant%0d", n_ack), winner, 0);
`endif
        chk($sformatf("t3_spacing%0d", n_ack), c - last_c, (n_ack == 0) ? 2 : 3);
        last_c = c;
        n_ack++;
        if (n_ack == 6) break;
      end
    end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("t3_ack_count", n_ack, 6);
    repeat (2) @(negedge clk);
    chk("t3_idle", busy, 1'b0);

    // Random traffic against a transaction-level model.
    reset_pulse();
    for (int i = 0; i < 256; i++) mm[i] = init_val(8'(i));
    k = 0; next_acc = 1; cur_v = 1'b0; pref = 0; exp_addr = 8'h00;
    cur_e = 0; cur_ack = 0; cur_w = 0; cur_we = 1'b0;
    cur_a = 8'h00; cur_d = 8'h00; cur_rd = 8'h00;
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; pwe[i] = 1'b0; pa[i] = 8'h00; pd[i] = 8'h00;
    end
    for (int it = 0; it < 3000; it++) begin
      for (int i = 0; i < 2; i++) begin
        if (pend[i] && cur_v && cur_ack == k && cur_w == i) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pwe[i]  = 1'($urandom_range(0, 1));
          pa[i]   = 8'h40 | 8'($urandom_range(0, 15));
          pd[i]   = 8'($urandom);
        end
        drive(i, pend[i], pwe[i], pa[i], pd[i]);
      end
      if (k + 1 >= next_acc && (pend[0] || pend[1])) begin
`ifdef RAM_ARB_RR_EN
        w = (pend[0] && pend[1]) ? pref : (pend[1] ? 1 : 0);
`else
        w = pend[0] ? 0 : 1;
`endif
        pref     = 1 - w;
        cur_v    = 1'b1;
        cur_e    = k + 1;
        cur_w    = w;
        cur_we   = pwe[w];
        cur_a    = pa[w];
        cur_d    = pd[w];
        cur_ack  = cur_e + (cur_we ? 1 : 2);
        next_acc = cur_ack + 2;
        exp_addr = cur_a;
        if (cur_we) mm[cur_a] = cur_d;
        else cur_rd = mm[cur_a];
      end
      @(negedge clk);
      k++;
      in_t   = cur_v && k >= cur_e && k <= cur_ack;
      e_we   = in_t && cur_we && k == cur_e;
      e_oe   = in_t && !cur_we && k == cur_e + 1;
      e_ack0 = in_t && k == cur_ack && cur_w == 0;
      e_ack1 = in_t && k == cur_ack && cur_w == 1;
      if (in_t && !cur_we && k == cur_ack) exp_rd[cur_w] = cur_rd;
      e_dat  = e_we ? cur_d : (e_oe ? cur_rd : 8'hFF);
      chk("rnd_we_oe_excl", ram_we && ram_oe, 1'b0);
      chk("rnd_ctrl", {busy, ram_we, ram_oe, m0_ack, m1_ack, ram_addr},
          {in_t, e_we, e_oe, e_ack0, e_ack1, exp_addr});
      chk("rnd_data", {ram_data, m0_rdata, m1_rdata}, {e_dat, exp_rd[0], exp_rd[1]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
